// File: rtl/clb_pkg.sv
// clb_pkg: shared constants for the gen2 configurable logic block.
//   LUTS44 slice geometry and the offsets of each field in the serial config
//   image. The image starts at bit 0 with the LUT tables:
//     LUT[33*n] | DFF_INIT[2n] | DFF_CEBYP[2n] | OMUX[2n] | CYINIT | CYSEL
package clb_pkg;

  localparam int LUTS44_CFG_SIZE = 33;  // two 16-entry tables + fracture bit
  localparam int LUTS44_IN_W     = 8;
  localparam int LUTS44_OUT_W    = 4;
  localparam int LUT_TAB_W       = 16;

  function automatic int init_off(input int n_slice);
    return LUTS44_CFG_SIZE * n_slice;
  endfunction

  function automatic int cebyp_off(input int n_slice);
    return init_off(n_slice) + 2 * n_slice;
  endfunction

  function automatic int omux_off(input int n_slice);
    return cebyp_off(n_slice) + 2 * n_slice;
  endfunction

  function automatic int cyinit_off(input int n_slice);
    return omux_off(n_slice) + 2 * n_slice;
  endfunction

  function automatic int cysel_off(input int n_slice);
    return cyinit_off(n_slice) + 1;
  endfunction

  function automatic int cfg_bits(input int n_slice);
    return cysel_off(n_slice) + 1;
  endfunction

endpackage

// File: rtl/clb_cfg_chain.sv
// clb_cfg_chain: serial config loader.
//   Shadow shift register (LSB word leaves on cfg_out, new word enters at MSB),
//   saturating word counter, loader FSM and the atomically committed active
//   register that drives the fabric.
// Ports: clk, crst (sync, active-high), cfg_in/cfg_we (shift), cfg_commit,
//   cfg_out (daisy-chain out), cfg_valid, cfg_act (active config image).
module clb_cfg_chain #(
  parameter int CFG_W    = 1,
  parameter int CFG_BITS = 158
) (
  input  logic                clk,
  input  logic                crst,
  input  logic [CFG_W-1:0]    cfg_in,
  input  logic                cfg_we,
  input  logic                cfg_commit,
  output logic [CFG_W-1:0]    cfg_out,
  output logic                cfg_valid,
  output logic [CFG_BITS-1:0] cfg_act
);

  localparam int CFG_WORDS = (CFG_BITS + CFG_W - 1) / CFG_W;
  localparam int CFG_SIZE  = CFG_WORDS * CFG_W;
  localparam int CNT_W     = $clog2(CFG_WORDS + 1);

  typedef enum logic [1:0] {ST_EMPTY, ST_SHIFT, ST_FULL, ST_ACTIVE} state_e;

  state_e              state, state_nxt;
  logic [CFG_SIZE-1:0] shadow;
  logic [CNT_W-1:0]    cnt;
  logic                fill_now;
  logic                do_commit;

  // The shift taking place this cycle completes (or keeps) a full image.
  assign fill_now = (cnt >= CNT_W'(CFG_WORDS - 1));

  always_ff @(posedge clk) begin
    if (crst) state <= ST_EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cfg_we)                               state_nxt = fill_now ? ST_FULL : ST_SHIFT;
    else if (state == ST_FULL && cfg_commit)  state_nxt = ST_ACTIVE;
  end

  // A shift always wins over a simultaneous commit.
  always_comb begin
    do_commit = (state == ST_FULL) && cfg_commit && !cfg_we;
  end

  always_ff @(posedge clk) begin
    if (crst) begin
      shadow  <= '0;
      cfg_out <= '0;
      cnt     <= '0;
    end else if (cfg_we) begin
      shadow  <= {cfg_in, shadow[CFG_SIZE-1:CFG_W]};
      cfg_out <= shadow[CFG_W-1:0];
      if (cnt != CNT_W'(CFG_WORDS)) cnt <= cnt + CNT_W'(1);
    end else if (do_commit) begin
      cnt <= '0;
    end
  end

  // Active image is untouched while a new one is being shifted in.
  always_ff @(posedge clk) begin
    if (crst) begin
      cfg_act   <= '0;
      cfg_valid <= 1'b0;
    end else if (do_commit) begin
      cfg_act   <= shadow[CFG_BITS-1:0];
      cfg_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/clb_luts44.sv
// clb_luts44: one LUTS44 slice, 8 inputs / 4 outputs / 33 config bits.
//   cfg[15:0]  table A (inputs lin[3:0])
//   cfg[31:16] table B (inputs lin[7:4])
//   cfg[32]    fracture: 1 -> each table splits into two LUT3 halves
//   lout[0] = A full LUT4, or A low half when fractured
//   lout[1] = A high half (indexed by lin[2:0])
//   lout[2], lout[3] = same for table B on lin[6:4]
// Ports: cfg (slice config), lin (slice inputs), lout (slice outputs).
module clb_luts44
  import clb_pkg::*;
(
  input  logic [LUTS44_CFG_SIZE-1:0] cfg,
  input  logic [LUTS44_IN_W-1:0]     lin,
  output logic [LUTS44_OUT_W-1:0]    lout
);

  logic [LUT_TAB_W-1:0] tab_a, tab_b;
  logic                 frac;

  assign tab_a = cfg[LUT_TAB_W-1:0];
  assign tab_b = cfg[2*LUT_TAB_W-1:LUT_TAB_W];
  assign frac  = cfg[2*LUT_TAB_W];

  assign lout[0] = frac ? tab_a[{1'b0, lin[2:0]}] : tab_a[lin[3:0]];
  assign lout[1] = tab_a[{1'b1, lin[2:0]}];
  assign lout[2] = frac ? tab_b[{1'b0, lin[6:4]}] : tab_b[lin[7:4]];
  assign lout[3] = tab_b[{1'b1, lin[6:4]}];

endmodule

// File: rtl/clb_gen2.sv
// clb_gen2: second-generation configurable logic block.
//   N_SLICE LUTS44 slices -> 2*N_SLICE-bit ripple carry -> output muxes -> DFFs,
//   all configured from a serially loaded, atomically committed image.
// Ports: clk, crst (sync config/system reset), I (LUT inputs), CIN/COUT (carry),
//   COMB_O (DFF D values), SYNC_O (DFF Q), RST/CE (fabric DFF control),
//   cfg_in/cfg_we/cfg_commit/cfg_out/cfg_valid (config chain).
module clb_gen2
  import clb_pkg::*;
#(
  parameter int N_SLICE = 4,
  parameter int CFG_W   = 1
) (
  input  logic                       clk,
  input  logic                       crst,
  input  logic [LUTS44_IN_W*N_SLICE-1:0] I,
  input  logic                       CIN,
  output logic                       COUT,
  output logic [2*N_SLICE-1:0]       COMB_O,
  output logic [2*N_SLICE-1:0]       SYNC_O,
  input  logic                       RST,
  input  logic                       CE,
  input  logic [CFG_W-1:0]           cfg_in,
  input  logic                       cfg_we,
  input  logic                       cfg_commit,
  output logic [CFG_W-1:0]           cfg_out,
  output logic                       cfg_valid
);

  localparam int OW       = 2 * N_SLICE;
  localparam int CFG_BITS = cfg_bits(N_SLICE);
  localparam int INIT_O   = init_off(N_SLICE);
  localparam int CEBYP_O  = cebyp_off(N_SLICE);
  localparam int OMUX_O   = omux_off(N_SLICE);
  localparam int CYINIT_O = cyinit_off(N_SLICE);
  localparam int CYSEL_O  = cysel_off(N_SLICE);

  logic [CFG_BITS-1:0] act;
  logic [OW-1:0]       dff_init, dff_cebyp, omux;
  logic                cyinit, cysel;

  clb_cfg_chain #(.CFG_W(CFG_W), .CFG_BITS(CFG_BITS)) u_chain (
    .clk        (clk),
    .crst       (crst),
    .cfg_in     (cfg_in),
    .cfg_we     (cfg_we),
    .cfg_commit (cfg_commit),
    .cfg_out    (cfg_out),
    .cfg_valid  (cfg_valid),
    .cfg_act    (act)
  );

  assign dff_init  = act[INIT_O  +: OW];
  assign dff_cebyp = act[CEBYP_O +: OW];
  assign omux      = act[OMUX_O  +: OW];
  assign cyinit    = act[CYINIT_O];
  assign cysel     = act[CYSEL_O];

  // Slices: even output of each LUT pair is propagate, odd is generate.
  logic [N_SLICE-1:0][LUTS44_OUT_W-1:0] lut_out;
  logic [OW-1:0]                        p, g, s, d;
  logic [OW:0]                          c;

  for (genvar k = 0; k < N_SLICE; k++) begin : g_slice
    clb_luts44 u_slice (
      .cfg  (act[k*LUTS44_CFG_SIZE +: LUTS44_CFG_SIZE]),
      .lin  (I[k*LUTS44_IN_W +: LUTS44_IN_W]),
      .lout (lut_out[k])
    );
    assign p[2*k]   = lut_out[k][0];
    assign g[2*k]   = lut_out[k][1];
    assign p[2*k+1] = lut_out[k][2];
    assign g[2*k+1] = lut_out[k][3];
  end

  // Ripple carry: propagate passes c[i], otherwise generate decides.
  always_comb begin
    c    = '0;
    c[0] = cysel ? cyinit : CIN;
    for (int i = 0; i < OW; i++) c[i+1] = p[i] ? c[i] : g[i];
  end

  for (genvar i = 0; i < OW; i++) begin : g_bit
    assign s[i] = p[i] ^ c[i];
    assign d[i] = omux[i] ? s[i] : p[i];
  end

  assign COMB_O = cfg_valid ? d : '0;
  assign COUT   = cfg_valid & c[OW];

  // DFFs: RST loads the configured init value; CE-bypass bits ignore CE.
  // A commit leaves Q alone; the new init value applies on the next RST.
  logic [OW-1:0] q, q_en;

  assign q_en = {OW{CE}} | dff_cebyp;

  always_ff @(posedge clk) begin
    if (crst || !cfg_valid) q <= '0;
    else if (RST)           q <= dff_init;
    else                    q <= (d & q_en) | (q & ~q_en);
  end

  assign SYNC_O = q;

endmodule
